// File: rtl/ps2_rx_controller_if.sv
// Scan-code output channel of the PS/2 receiver: valid/ready handshake plus
// the per-frame status pulses and the busy flag.
interface ps2_rx_controller_if;
    logic [7:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    modport master (
        output code_out,
        output code_valid,
        input  code_ready,
        output frame_err,
        output overflow,
        output busy
    );

    modport slave (
        input  code_out,
        input  code_valid,
        output code_ready,
        input  frame_err,
        input  overflow,
        input  busy
    );
endinterface

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receive controller: pin synchronisation, 11-bit frame assembly
// with start/stop/odd-parity and inter-bit timeout checks, scan-code FIFO.
module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clock_fpga,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_rx_controller_if.master rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_PTR  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2, fe;
    logic [10:0]   frame;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          start_frame, store_bit, clear_cnt, tmo_clr, tmo_inc;
    logic          err_nxt, push_req, frame_ok;
    logic          frame_err_q, overflow_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, rd_next, count;
    logic [7:0]    head_q;
    logic          empty, full, pop, push, overflow_nxt;

    // Idle-high lines, so the synchronisers reset to 1 and no edge is seen at start-up.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            fe       <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
            fe       <= clk_prev & ~clk_s2;
        end
    end

    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        store_bit   = 1'b0;
        clear_cnt   = 1'b0;
        tmo_clr     = 1'b0;
        tmo_inc     = 1'b0;
        err_nxt     = 1'b0;
        push_req    = 1'b0;
        case (state)
            IDLE: begin
                if (fe && !data_s2) begin
                    start_frame = 1'b1;
                    tmo_clr     = 1'b1;
                    state_nxt   = RECEIVE;
                end
            end
            RECEIVE: begin
                if (fe) begin
                    store_bit = 1'b1;
                    tmo_clr   = 1'b1;
                    if (bit_cnt == 4'd10) state_nxt = CHECK;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    clear_cnt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            CHECK: begin
                clear_cnt = 1'b1;
                state_nxt = IDLE;
                if (frame_ok) push_req = 1'b1;
                else          err_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            frame   <= '0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (start_frame) begin
                frame[0] <= 1'b0;
                bit_cnt  <= 4'd1;
            end else if (store_bit) begin
                frame[bit_cnt] <= data_s2;
                bit_cnt        <= bit_cnt + 4'd1;
            end else if (clear_cnt) begin
                bit_cnt <= '0;
            end
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Extra pointer MSB distinguishes full from empty when the slot indices match.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_PTR);
    assign pop          = !empty && rx.code_ready;
    assign push         = push_req && (!full || pop);
    assign overflow_nxt = push_req && full && !pop;
    assign rd_next      = pop ? rd_ptr + PTR_ONE : rd_ptr;

    // NOTE: the storage array is not reset; only pointers and the head register are.
    always_ff @(posedge clock_fpga) begin
        if (push) mem[wr_ptr[AW-1:0]] <= frame[8:1];
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            head_q      <= 8'h00;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr      <= rd_next;
            frame_err_q <= err_nxt;
            overflow_q  <= overflow_nxt;
            // Head follows the pushed code when it lands in the slot about to be read.
            if (push && (wr_ptr == rd_next)) head_q <= frame[8:1];
            else if (pop)                    head_q <= mem[rd_next[AW-1:0]];
        end
    end

    assign rx.code_out   = head_q;
    assign rx.code_valid = !empty;
    assign rx.frame_err  = frame_err_q;
    assign rx.overflow   = overflow_q;
    assign rx.busy       = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx_controller.sv
// Self-checking bench for ps2_rx_controller: table of single frames, directed
// timeout/overflow/reset sequences, then randomized frames against a frame-rule model.
module tb_ps2_rx_controller;
    localparam int TMO   = 64;
    localparam int DEPTH = 4;
    localparam int HALF  = 8;

    logic clock_fpga = 1'b0;
    logic reset, ps2_clk, ps2_data;
    logic manual_ready = 1'b0;
    logic rand_ready   = 1'b0;
    logic rnd_ready    = 1'b1;

    ps2_rx_controller_if rx();
    assign rx.code_ready = rand_ready ? rnd_ready : manual_ready;

    ps2_rx_controller #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clock_fpga (clock_fpga),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx         (rx)
    );

    always #5 clock_fpga = ~clock_fpga;

    // Monitor: counts pulses and collects popped codes on the falling edge.
    int         cyc = 0;
    int         err_pulses = 0, ovf_pulses = 0, wide_pulses = 0, valid_cycles = 0;
    int         last_err_cyc = 0;
    logic       err_prev = 1'b0, ovf_prev = 1'b0;
    logic [7:0] pop_q[$];
    int         pop_cyc_q[$];

    always @(negedge clock_fpga) begin
        cyc <= cyc + 1;
        if (reset) begin
            err_prev <= 1'b0;
            ovf_prev <= 1'b0;
        end else begin
            if (rx.frame_err) begin
                err_pulses   <= err_pulses + 1;
                last_err_cyc <= cyc;
                if (err_prev) wide_pulses <= wide_pulses + 1;
            end
            if (rx.overflow) begin
                ovf_pulses <= ovf_pulses + 1;
                if (ovf_prev) wide_pulses <= wide_pulses + 1;
            end
            err_prev <= rx.frame_err;
            ovf_prev <= rx.overflow;
            if (rx.code_valid) valid_cycles <= valid_cycles + 1;
            if (rx.code_valid && rx.code_ready) begin
                pop_q.push_back(rx.code_out);
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock_fpga);
            #1;
            rnd_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int checks = 0, errors = 0;
    int rd_idx = 0;
    int last_fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_fpga);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                             input logic bad_stop);
        return {~bad_stop, ~(^code) ^ bad_par, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_bits(f, 11);
        tick(12);
    endtask

    task automatic expect_pop(input string name, input logic [7:0] exp);
        int budget;
        budget = 400;
        while (pop_q.size() <= rd_idx && budget > 0) begin
            tick(1);
            budget--;
        end
        if (pop_q.size() > rd_idx) begin
            check(name, 32'(pop_q[rd_idx]), 32'(exp));
            rd_idx++;
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: no pop within budget, expected 0x%0h", name, exp);
        end
    endtask

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        int         exp_err;
        int         exp_pop;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         e0, v0, p0, o0, ovf_base, exp_err, dp;
        logic [7:0] code, exp_q[$];
        logic [10:0] f;
        int         kind;
        logic       good;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 0, 1};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 0, 1};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 0, 1};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 1, 0};

        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        check("reset code_valid", 32'(rx.code_valid), 0);
        check("reset code_out", 32'(rx.code_out), 0);
        check("reset frame_err", 32'(rx.frame_err), 0);
        check("reset overflow", 32'(rx.overflow), 0);
        check("reset busy", 32'(rx.busy), 0);
        reset = 1'b0;
        tick(3);

        // Single frames with the consumer always ready.
        manual_ready = 1'b1;
        foreach (vecs[k]) begin
            e0 = err_pulses;
            v0 = valid_cycles;
            p0 = pop_q.size();
            send_frame(mk_frame(vecs[k].code, vecs[k].bad_par, vecs[k].bad_stop));
            check($sformatf("vec%0d frame_err count", k), 32'(err_pulses - e0), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d pop count", k), 32'(pop_q.size() - p0), 32'(vecs[k].exp_pop));
            check($sformatf("vec%0d valid cycles", k), 32'(valid_cycles - v0), 32'(vecs[k].exp_pop));
            if (vecs[k].exp_pop > 0 && pop_q.size() > p0)
                check($sformatf("vec%0d code", k), 32'(pop_q[p0]), 32'(vecs[k].code));
            if (vecs[k].exp_err > 0) begin
                dp = last_err_cyc - last_fall_cyc;
                check($sformatf("vec%0d err latency window", k), 32'(dp >= 2 && dp <= 6), 1);
            end
            check($sformatf("vec%0d busy idle", k), 32'(rx.busy), 0);
            rd_idx = pop_q.size();
        end

        // Inter-bit timeout after five bits, then recovery with 0xF0.
        e0 = err_pulses;
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 5);
        check("timeout busy mid-frame", 32'(rx.busy), 1);
        tick(TMO / 2);
        check("timeout not early", 32'(err_pulses - e0), 0);
        tick(TMO);
        check("timeout frame_err", 32'(err_pulses - e0), 1);
        check("timeout busy falls", 32'(rx.busy), 0);
        send_frame(mk_frame(8'hF0, 1'b0, 1'b0));
        expect_pop("after timeout code", 8'hF0);
        check("after timeout no extra err", 32'(err_pulses - e0), 1);

        // Fill the FIFO with the consumer stalled; the fifth frame overflows.
        manual_ready = 1'b0;
        o0 = ovf_pulses;
        for (int c = 1; c <= 5; c++) begin
            send_frame(mk_frame(8'(c), 1'b0, 1'b0));
            check($sformatf("overflow after frame %0d", c), 32'(ovf_pulses - o0), (c == 5) ? 1 : 0);
        end
        check("full code_valid", 32'(rx.code_valid), 1);
        check("full head", 32'(rx.code_out), 32'h01);
        check("stalled no pops", 32'(pop_q.size()), 32'(rd_idx));
        manual_ready = 1'b1;
        for (int c = 1; c <= 4; c++) expect_pop($sformatf("drain code %0d", c), 8'(c));
        for (int k = 1; k <= 3; k++)
            check($sformatf("drain back-to-back %0d", k),
                  32'(pop_cyc_q[rd_idx - 4 + k] - pop_cyc_q[rd_idx - 5 + k]), 1);
        tick(3);
        check("drain empty", 32'(rx.code_valid), 0);

        // Full FIFO with a pop in the CHECK cycle of a new frame: the push is accepted.
        manual_ready = 1'b0;
        for (int c = 1; c <= 4; c++) send_frame(mk_frame(8'(c), 1'b0, 1'b0));
        o0 = ovf_pulses;
        f = mk_frame(8'h06, 1'b0, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        tick(HALF);
        ps2_clk = 1'b0;
        tick(4);
        manual_ready = 1'b1;
        tick(HALF - 4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(12);
        check("pop+push no overflow", 32'(ovf_pulses - o0), 0);
        for (int c = 1; c <= 4; c++) expect_pop($sformatf("pop+push code %0d", c), 8'(c));
        expect_pop("pop+push new code", 8'h06);
        tick(3);
        check("pop+push empty", 32'(rx.code_valid), 0);

        // Reset in the middle of a frame.
        manual_ready = 1'b0;
        e0 = err_pulses;
        send_bits(mk_frame(8'h55, 1'b0, 1'b0), 6);
        check("pre-reset busy", 32'(rx.busy), 1);
        reset = 1'b1;
        tick(1);
        check("in-reset busy", 32'(rx.busy), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        send_frame(mk_frame(8'h1C, 1'b0, 1'b0));
        check("post-reset code_valid", 32'(rx.code_valid), 1);
        check("post-reset code_out", 32'(rx.code_out), 32'h1C);
        manual_ready = 1'b1;
        expect_pop("post-reset pop", 8'h1C);
        tick(2);
        check("post-reset single entry", 32'(rx.code_valid), 0);
        check("post-reset no frame_err", 32'(err_pulses - e0), 0);

        // Randomized frames, random consumer stalls, frame-rule reference model.
        e0 = err_pulses;
        ovf_base = ovf_pulses;
        exp_err = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            code = 8'($urandom);
            kind = $urandom_range(9);
            f = mk_frame(code, kind == 7 || kind == 9, kind == 8 || kind == 9);
            good = (f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(f[9:1]) % 2 == 1);
            if (good) exp_q.push_back(code);
            else      exp_err++;
            send_frame(f);
            tick($urandom_range(30, 5));
        end
        rand_ready = 1'b0;
        manual_ready = 1'b1;
        foreach (exp_q[k]) expect_pop($sformatf("random code %0d", k), exp_q[k]);
        tick(5);
        check("random frame_err count", 32'(err_pulses - e0), 32'(exp_err));
        check("random no overflow", 32'(ovf_pulses - ovf_base), 0);
        check("random no extra pops", 32'(pop_q.size()), 32'(rd_idx));
        check("pulse widths", 32'(wide_pulses), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
